key_conditioner: RTL and testbench

//  Conditions one raw push-button pin for the tail-light FSM: 2-FF synchronizer, counter-based

---
 rtl/key_conditioner_if.sv | 30 +++
 rtl/key_conditioner.sv | 143 ++++++++++++++
 tb/tb_key_conditioner.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: the raw pin going in, the conditioned
// level, strobes and toggle latch coming out.
interface key_conditioner_if;
    logic btn_in;
    logic level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic toggle;

    // Whoever owns the pin and consumes the conditioned outputs.
    modport master (
        output btn_in,
        input  level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  toggle
    );

    // The conditioner itself.
    modport slave (
        input  btn_in,
        output level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output toggle
    );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner: one push-button pin -> synchronised, debounced level with
// press/release strobes, a long-press strobe and a press-toggled latch.
// Every output is a flop. Each strobe lasts exactly one clock.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 200000,   // stable samples to accept a change (>=2)
    parameter int HOLD_CYCLES     = 10000000, // edges after press_pulse for long_pulse (>=1)
    parameter bit ACTIVE_LOW      = 1'b1      // 1: pin reads 0 while pressed
) (
    input  logic               clk,
    input  logic               reset,
    key_conditioner_if.slave   bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    state_t              state_reg;
    logic                sync1_reg;
    logic                sync2_reg;
    logic [DB_W-1:0]     db_cnt_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic                level_reg;
    logic                press_pulse_reg;
    logic                release_pulse_reg;
    logic                long_pulse_reg;
    logic                toggle_reg;

    // Normalised pressed flag: 1 means pressed regardless of pin polarity.
    logic s;
    // Release is being accepted on this edge; it wins over a long press.
    logic release_accept;
    // The key counts as held (hold timer running) in these two states.
    logic hold_active;

    assign s              = sync2_reg ^ ACTIVE_LOW;
    assign release_accept = (state_reg == REL_WAIT) && !s && (db_cnt_reg == DB_LAST);
    assign hold_active    = (state_reg == HELD) || (state_reg == REL_WAIT);

    // Two-flop synchroniser; resets to the pin's released level so that a
    // key held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= ACTIVE_LOW;
            sync2_reg <= ACTIVE_LOW;
        end else begin
            sync1_reg <= bus.btn_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce FSM with registered level, strobes, toggle latch and hold timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            db_cnt_reg        <= '0;
            hold_cnt_reg      <= '0;
            level_reg         <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            long_pulse_reg    <= 1'b0;
            toggle_reg        <= 1'b0;
        end else begin
            // Strobes fall back to zero unless re-asserted below.
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            long_pulse_reg    <= 1'b0;

            // Hold timer counts from the press strobe and saturates one past
            // the firing value, so long_pulse can only fire once per press.
            if (hold_active) begin
                if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                end
                if ((hold_cnt_reg == HOLD_LAST) && !release_accept) begin
                    long_pulse_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (s) begin
                        state_reg  <= PRESS_WAIT;
                        db_cnt_reg <= DB_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        // Bounce: drop back silently.
                        state_reg <= IDLE;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg       <= HELD;
                        level_reg       <= 1'b1;
                        press_pulse_reg <= 1'b1;
                        toggle_reg      <= ~toggle_reg;
                        hold_cnt_reg    <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_reg  <= REL_WAIT;
                        db_cnt_reg <= DB_ONE;
                    end
                end
                REL_WAIT: begin
                    if (s) begin
                        // Release bounce: still held, hold timer keeps running.
                        state_reg <= HELD;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg         <= IDLE;
                        level_reg         <= 1'b0;
                        release_pulse_reg <= 1'b1;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.level         = level_reg;
    assign bus.press_pulse   = press_pulse_reg;
    assign bus.release_pulse = release_pulse_reg;
    assign bus.long_pulse    = long_pulse_reg;
    assign bus.toggle        = toggle_reg;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16,
// active-low pin. Edge k counts posedges after a pin change; outputs are
// sampled 1 time unit after each posedge.
module tb_key_conditioner;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    logic exp_toggle;

    key_conditioner_if bus ();

    key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.btn_in = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({bus.level, bus.toggle, bus.press_pulse, bus.release_pulse, bus.long_pulse} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b want 00000",
                     {bus.level, bus.toggle, bus.press_pulse, bus.release_pulse, bus.long_pulse});
        end
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            n_cmp++;
            if ({bus.level, bus.press_pulse, bus.release_pulse, bus.long_pulse} !== 4'b0) begin
                n_bad++;
                $display("FAIL idle_quiet k=%0d got %b want 0000", k,
                         {bus.level, bus.press_pulse, bus.release_pulse, bus.long_pulse});
            end
        end
        exp_toggle = 1'b0;
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_press();
        bus.btn_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 5) exp_toggle = ~exp_toggle;
            n_cmp++;
            if (bus.press_pulse !== (k == 5) || bus.level !== (k >= 5) || bus.toggle !== exp_toggle) begin
                n_bad++;
                $display("FAIL press k=%0d got p=%b l=%b t=%b want p=%b l=%b t=%b", k,
                         bus.press_pulse, bus.level, bus.toggle, (k == 5), (k >= 5), exp_toggle);
            end
        end
        bus.btn_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_cmp++;
            if (bus.release_pulse !== (k == 5) || bus.level !== (k < 5) || bus.long_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL press_release k=%0d got r=%b l=%b lp=%b want r=%b l=%b lp=0", k,
                         bus.release_pulse, bus.level, bus.long_pulse, (k == 5), (k < 5));
            end
        end
        $display("test_press done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 32; k++) begin
            if (k < 20) bus.btn_in = ((k / 2) % 2 == 1);
            else        bus.btn_in = 1'b1;
            step();
            n_cmp++;
            if (bus.press_pulse !== 1'b0 || bus.level !== 1'b0 || bus.toggle !== exp_toggle) begin
                n_bad++;
                $display("FAIL bounce k=%0d got p=%b l=%b t=%b want p=0 l=0 t=%b", k,
                         bus.press_pulse, bus.level, bus.toggle, exp_toggle);
            end
        end
        $display("test_bounce done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_long_press();
        bus.btn_in = 1'b0;
        for (int k = 0; k < 36; k++) begin
            step();
            if (k == 5) exp_toggle = ~exp_toggle;
            n_cmp++;
            if (bus.press_pulse !== (k == 5) || bus.long_pulse !== (k == 21) || bus.toggle !== exp_toggle) begin
                n_bad++;
                $display("FAIL long k=%0d got p=%b lp=%b t=%b want p=%b lp=%b t=%b", k,
                         bus.press_pulse, bus.long_pulse, bus.toggle, (k == 5), (k == 21), exp_toggle);
            end
        end
        bus.btn_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_cmp++;
            if (bus.release_pulse !== (k == 5) || bus.level !== (k < 5) || bus.long_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL long_release k=%0d got r=%b l=%b lp=%b want r=%b l=%b lp=0", k,
                         bus.release_pulse, bus.level, bus.long_pulse, (k == 5), (k < 5));
            end
        end
        $display("test_long_press done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_back_to_back();
        int cnt_press;
        int cnt_rel;
        cnt_press = 0;
        cnt_rel   = 0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 40; k++) begin
                bus.btn_in = (k >= 12);
                step();
                if (k == 5) exp_toggle = ~exp_toggle;
                if (bus.press_pulse === 1'b1)   cnt_press++;
                if (bus.release_pulse === 1'b1) cnt_rel++;
                n_cmp++;
                if (bus.press_pulse !== (k == 5) || bus.release_pulse !== (k == 17) ||
                    bus.long_pulse !== 1'b0 || bus.toggle !== exp_toggle) begin
                    n_bad++;
                    $display("FAIL b2b rep=%0d k=%0d got p=%b r=%b lp=%b t=%b want p=%b r=%b lp=0 t=%b",
                             rep, k, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.toggle,
                             (k == 5), (k == 17), exp_toggle);
                end
                n_cmp++;
                if (bus.press_pulse === 1'b1 && bus.release_pulse === 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_coincident rep=%0d k=%0d got p=1 r=1 want not both", rep, k);
                end
            end
            n_cmp++;
            if (bus.toggle !== (rep == 0)) begin
                n_bad++;
                $display("FAIL b2b_toggle rep=%0d got %b want %b", rep, bus.toggle, (rep == 0));
            end
        end
        n_cmp++;
        if (cnt_press != 2 || cnt_rel != 2) begin
            n_bad++;
            $display("FAIL b2b_counts got press=%0d release=%0d want press=2 release=2", cnt_press, cnt_rel);
        end
        $display("test_back_to_back done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_reset_mid_press();
        bus.btn_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 5) exp_toggle = ~exp_toggle;
            n_cmp++;
            if (bus.press_pulse !== (k == 5) || bus.toggle !== exp_toggle) begin
                n_bad++;
                $display("FAIL mid_press k=%0d got p=%b t=%b want p=%b t=%b", k,
                         bus.press_pulse, bus.toggle, (k == 5), exp_toggle);
            end
        end
        reset = 1'b1;
        #1;
        exp_toggle = 1'b0;
        n_cmp++;
        if ({bus.level, bus.toggle, bus.press_pulse, bus.release_pulse, bus.long_pulse} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_reset_async got %b want 00000",
                     {bus.level, bus.toggle, bus.press_pulse, bus.release_pulse, bus.long_pulse});
        end
        repeat (3) step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 5) exp_toggle = ~exp_toggle;
            n_cmp++;
            if (bus.press_pulse !== (k == 5) || bus.level !== (k >= 5) || bus.toggle !== exp_toggle) begin
                n_bad++;
                $display("FAIL after_reset k=%0d got p=%b l=%b t=%b want p=%b l=%b t=%b", k,
                         bus.press_pulse, bus.level, bus.toggle, (k == 5), (k >= 5), exp_toggle);
            end
        end
        bus.btn_in = 1'b1;
        repeat (8) step();
        $display("test_reset_mid_press done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        exp_toggle = 1'b0;
        reset      = 1'b1;
        bus.btn_in = 1'b1;
        test_reset();
        test_press();
        test_bounce();
        test_long_press();
        test_back_to_back();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
